q_sys_out_port_sequencer: RTL

Q_SYS_OUT_PORT_SEQUENCER -- requirements
Module: q_sys_out_port_sequencer

---
 rtl/q_sys_out_port_sequencer_if.sv | 24 ++
 rtl/q_sys_out_port_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/q_sys_out_port_sequencer_if.sv
// Bus bundle for the output-port sequencer: config slave side plus the PIO master side.
interface q_sys_out_port_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  // Sequencer side: config bus target, PIO bus initiator.
  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, m_address, m_chipselect, m_write_n, m_writedata
  );

  // Host side: drives config writes, observes PIO traffic.
  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, m_address, m_chipselect, m_write_n, m_writedata
  );
endinterface

// File: rtl/q_sys_out_port_sequencer.sv
// Drives a PIO output port through a programmable train of assert/idle pulses
// (HOLD/GAP timing, repeat count) with abort, done/aborted flags and a level irq.
module q_sys_out_port_sequencer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  q_sys_out_port_sequencer_if.slave    bus,
  output logic                         irq
);

  localparam int unsigned REG_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned REP_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ASSERT,
    S_HOLD,
    S_WR_IDLE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [REG_W-1:0]   values_q;
  logic [REG_W-1:0]   timing_q;
  logic [REP_W-1:0]   repeat_q;
  logic [REP_W-1:0]   remaining_q, remaining_d, rem_dec;
  logic [CNT_W-1:0]   cnt_q, cnt_d, hold_init, gap_init;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               pend_q, pend_d;
  logic               cs_d;
  logic [REG_W-1:0]   wd_d;

  logic               wr, busy, start, abort, clr, count_wr;
  logic [DATA_WIDTH-1:0] assert_val, idle_val;

  assign wr       = bus.chipselect && !bus.write_n;
  assign busy     = (state_q != S_IDLE);
  assign start    = wr && (bus.address == 2'd0) && bus.writedata[0];
  assign abort    = wr && (bus.address == 2'd0) && bus.writedata[1];
  assign clr      = wr && (bus.address == 2'd0) && bus.writedata[2];
  assign count_wr = wr && (bus.address == 2'd3);

  assign assert_val = values_q[DATA_WIDTH-1:0];
  assign idle_val   = values_q[DATA_WIDTH+7:8];

  // A programmed 0 behaves as 1 cycle, so the counters load max(N,1)-1.
  assign hold_init = (timing_q[15:0]  == '0) ? '0 : timing_q[15:0]  - CNT_W'(1);
  assign gap_init  = (timing_q[31:16] == '0) ? '0 : timing_q[31:16] - CNT_W'(1);

  assign bus.m_address = '0;
  assign irq           = done_q;

  // Config registers are frozen while a sequence runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      values_q <= '0;
      timing_q <= '0;
      repeat_q <= '0;
    end else if (wr && !busy) begin
      case (bus.address)
        2'd1:    values_q <= bus.writedata;
        2'd2:    timing_q <= bus.writedata;
        2'd3:    repeat_q <= bus.writedata[REP_W-1:0];
        default: ;
      endcase
    end
  end

  // Zero-wait combinational readback.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd1:    bus.readdata = values_q;
      2'd2:    bus.readdata = timing_q;
      2'd3:    bus.readdata = {busy, done_q, aborted_q, 21'b0, remaining_q};
      default: bus.readdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      remaining_q      <= '0;
      done_q           <= 1'b0;
      aborted_q        <= 1'b0;
      pend_q           <= 1'b0;
      bus.m_chipselect <= 1'b0;
      bus.m_write_n    <= 1'b1;
      bus.m_writedata  <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      remaining_q      <= remaining_d;
      done_q           <= done_d;
      aborted_q        <= aborted_d;
      pend_q           <= pend_d;
      bus.m_chipselect <= cs_d;
      bus.m_write_n    <= !cs_d;
      bus.m_writedata  <= wd_d;
    end
  end

  // Next state; flag clears come first so a same-cycle set event overrides them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    done_d      = done_q;
    aborted_d   = aborted_q;
    pend_d      = pend_q;
    rem_dec     = remaining_q - REP_W'(1);
    cs_d        = 1'b0;
    wd_d        = '0;

    if (clr) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort && (repeat_q != '0)) begin
          remaining_d = repeat_q;
          done_d      = 1'b0;
          aborted_d   = 1'b0;
          pend_d      = 1'b0;
          state_d     = S_WR_ASSERT;
        end else if (count_wr) begin
          remaining_d = bus.writedata[REP_W-1:0];
        end
      end
      S_WR_ASSERT: begin
        if (abort) begin
          pend_d  = 1'b1;
          state_d = S_WR_IDLE;
        end else begin
          cnt_d   = hold_init;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (abort) begin
          pend_d  = 1'b1;
          state_d = S_WR_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_WR_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WR_IDLE: begin
        // An abort ends the train here with remaining left untouched.
        if (abort || pend_q) begin
          pend_d    = 1'b0;
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          remaining_d = rem_dec;
          if (rem_dec == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = gap_init;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          pend_d  = 1'b1;
          state_d = S_WR_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_WR_ASSERT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Master outputs are registered from the state being entered.
    cs_d = (state_d == S_WR_ASSERT) || (state_d == S_WR_IDLE);
    if (state_d == S_WR_ASSERT) begin
      wd_d = REG_W'(assert_val);
    end else if (state_d == S_WR_IDLE) begin
      wd_d = REG_W'(idle_val);
    end
  end

endmodule
